signal_monitor: RTL and testbench
=================================

# signal_monitor

Downstream analysis stage for the lab's single-bit sequential outputs (D/JK flip-flop `q`, FSM `y`). On a `start` pulse it samples one 1-bit signal for a fixed window of clock cycles and reports five statistics, then pulses `done`:

- rising-edge count
- falling-edge count
- high-sample count
- longest consecutive high run
- final level

Results are held until the next accepted `start`, so a bench or display stage can read them at leisure.

## Interface
- `WINDOW`, default 16: number of samples per measurement, ≥ 1.
- `CNT_W`, default 8: width of every statistic output. Counts saturate at 2^CNT_W−1.

- `clk`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request a measurement. Sampled every edge.
- `sig`  in  1: signal under analysis. Sampled every edge.
- `busy`  out  1: high while a window is being captured.
- `done`  out  1: one-cycle pulse when results update.
- `rise_cnt`  out  CNT_W: 0→1 transitions in the window.
- `fall_cnt`  out  CNT_W: 1→0 transitions in the window.
- `high_cnt`  out  CNT_W: samples equal to 1.
- `max_run`  out  CNT_W: longest run of consecutive 1 samples.
- `final_level`  out  1: value of the last sample.

## Operation
- FSM states:
  - IDLE: waiting for `start`.
  - MEASURE: capturing the window.
  - DONE: lasts exactly one cycle.
- IDLE or DONE with `start`=1 at edge k → MEASURE.
  - `sig` at edge k is latched as the reference level. It is not counted as a sample.
  - The internal accumulators and the run counter are cleared.
- MEASURE: `sig` is sampled at edges k+1 … k+WINDOW. Each sample is compared with the previous value, which at edge k+1 is the reference.
  - prev 0, sample 1 → increment rise.
  - prev 1, sample 0 → increment fall.
  - sample 1 → increment high and increment the current run.
  - sample 0 → current run cleared.
  - max = max(max, updated run). This uses the post-increment run, so a run ending on the last sample is included.
- After sample WINDOW is taken at edge k+WINDOW, the FSM moves to DONE. At the same edge, all five result registers load the final accumulator values, including the last sample.
- DONE → IDLE on the next edge, unless `start`=1, in which case → MEASURE (back-to-back operation).
- `start` in MEASURE is ignored. It is not queued.
- All accumulators and the run counter saturate at 2^CNT_W−1 and never wrap.
- The window counter has its own width, $clog2(WINDOW+1), independent of CNT_W.
- Result outputs change only at the DONE-entry edge. During MEASURE they hold the previous results.

## Timing
- Reset edge (`reset`=1 takes priority over everything):
  - state = IDLE.
  - `busy`=0, `done`=0.
  - All statistics = 0, `final_level`=0.
- Reset during MEASURE aborts the window. No `done` is produced.
- `busy` = (state == MEASURE). It is high from after edge k until edge k+WINDOW, i.e. WINDOW cycles.
- `done` = (state == DONE). It is high for exactly one cycle, after edge k+WINDOW.
- Latency from the `start` edge to `done` high is WINDOW cycles. Results are valid in the same cycle `done` is high.
- Back-to-back `start` during DONE: `busy` is high the following cycle, and `done` pulses are spaced WINDOW+1 cycles apart.

## Structure
- Package `signal_monitor_pkg` holds:
  - `typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_DONE} mon_state_t`
  - a `function sat_inc(value, max)` helper.
- Sub-module `sat_counter` (parameter W; ports `clk`, `reset`, `clr`, `inc`, `q`) is instantiated for the rise, fall and high accumulators and for the current-run counter.
- The FSM, window counter, max tracker and result registers live in the top module.

## Test plan
All scenarios use WINDOW=8, CNT_W=8 unless stated.
- Reference 0, `sig` held at 0 → `done` 8 cycles after start; all counts 0; `final_level`=0.
- Reference 0, samples 1,0,1,0,1,0,1,0 → rise=4, fall=4, high=4, max_run=1, `final_level`=0.
- Reference 0, samples 0,1,1,1,0,1,1,0 → rise=2, fall=2, high=5, max_run=3, `final_level`=0.
- Reference 1, `sig` held at 1 → rise=0, fall=0, high=8, max_run=8, `final_level`=1.
  - A `start` pulse mid-window is ignored.
  - A second `start` in the DONE cycle begins a new window immediately; `done` pulses are 9 cycles apart.
- Reset asserted one cycle after sample 4 → `busy`=0, all outputs 0, no `done`.
  - A fresh `start` afterwards produces correct results.
- Saturation, WINDOW=10, CNT_W=3, `sig`=1 throughout → high=7, max_run=7, rise=0, with no wrap to 0.

Source files
------------

// File: rtl/signal_monitor_pkg.sv
// signal_monitor_pkg: shared FSM state type and saturating-increment helper.
package signal_monitor_pkg;

    typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_DONE} mon_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max);
        return (value >= max) ? max : value + 32'd1;
    endfunction

endpackage

// File: rtl/signal_monitor_if.sv
// signal_monitor_if: request/sample inputs and statistic results of the monitor.
interface signal_monitor_if #(parameter int CNT_W = 8);
    logic             start;
    logic             sig;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] rise_cnt;
    logic [CNT_W-1:0] fall_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] max_run;
    logic             final_level;

    modport master (
        output start, sig,
        input  busy, done, rise_cnt, fall_cnt, high_cnt, max_run, final_level
    );

    modport slave (
        input  start, sig,
        output busy, done, rise_cnt, fall_cnt, high_cnt, max_run, final_level
    );
endinterface

// File: rtl/signal_monitor_sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones instead of wrapping.
module sat_counter
    import signal_monitor_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    localparam logic [W-1:0] QMAX = '1;

    always_ff @(posedge clk)
        if (reset || clr)
            q <= '0;
        else if (inc)
            q <= W'(sat_inc(32'(q), 32'(QMAX)));
endmodule

// File: rtl/signal_monitor.sv
// signal_monitor: samples one bit for WINDOW cycles after start and reports
// edge counts, high count, longest high run and final level.
module signal_monitor
    import signal_monitor_pkg::*;
#(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8
) (
    input logic clk,
    input logic reset,
    signal_monitor_if.slave mon
);
    localparam int WC_W = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] CMAX = '1;

    mon_state_t       state;
    logic [WC_W-1:0]  wcnt;
    logic             prev;
    logic [CNT_W-1:0] rise, fall, high, run, max_acc;
    logic [CNT_W-1:0] rise_n, fall_n, high_n, run_n, max_n;
    logic [CNT_W-1:0] res_rise, res_fall, res_high, res_max;
    logic             res_final;
    logic             meas, accept, last;
    logic             rise_inc, fall_inc, high_inc, run_clr;

    assign meas     = state == S_MEASURE;
    assign accept   = mon.start && !meas;
    assign last     = meas && wcnt == WC_W'(WINDOW - 1);
    assign rise_inc = meas && !prev && mon.sig;
    assign fall_inc = meas && prev && !mon.sig;
    assign high_inc = meas && mon.sig;
    assign run_clr  = accept || (meas && !mon.sig);

    sat_counter #(.W(CNT_W)) u_rise (.clk(clk), .reset(reset), .clr(accept),  .inc(rise_inc), .q(rise));
    sat_counter #(.W(CNT_W)) u_fall (.clk(clk), .reset(reset), .clr(accept),  .inc(fall_inc), .q(fall));
    sat_counter #(.W(CNT_W)) u_high (.clk(clk), .reset(reset), .clr(accept),  .inc(high_inc), .q(high));
    sat_counter #(.W(CNT_W)) u_run  (.clk(clk), .reset(reset), .clr(run_clr), .inc(high_inc), .q(run));

    // Post-update accumulator values so the last sample lands in the results.
    always_comb begin
        rise_n = rise_inc ? CNT_W'(sat_inc(32'(rise), 32'(CMAX))) : rise;
        fall_n = fall_inc ? CNT_W'(sat_inc(32'(fall), 32'(CMAX))) : fall;
        high_n = high_inc ? CNT_W'(sat_inc(32'(high), 32'(CMAX))) : high;
        run_n  = mon.sig ? CNT_W'(sat_inc(32'(run), 32'(CMAX))) : '0;
        max_n  = (run_n > max_acc) ? run_n : max_acc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            wcnt      <= '0;
            prev      <= 1'b0;
            max_acc   <= '0;
            res_rise  <= '0;
            res_fall  <= '0;
            res_high  <= '0;
            res_max   <= '0;
            res_final <= 1'b0;
        end else begin
            state   <= accept ? S_MEASURE : last ? S_DONE : meas ? S_MEASURE : S_IDLE;
            wcnt    <= accept ? '0 : meas ? wcnt + WC_W'(1) : wcnt;
            max_acc <= accept ? '0 : meas ? max_n : max_acc;
            if (accept || meas)
                prev <= mon.sig;
            if (last) begin
                res_rise  <= rise_n;
                res_fall  <= fall_n;
                res_high  <= high_n;
                res_max   <= max_n;
                res_final <= mon.sig;
            end
        end
    end

    assign mon.busy        = meas;
    assign mon.done        = state == S_DONE;
    assign mon.rise_cnt    = res_rise;
    assign mon.fall_cnt    = res_fall;
    assign mon.high_cnt    = res_high;
    assign mon.max_run     = res_max;
    assign mon.final_level = res_final;
endmodule

// File: tb/tb_signal_monitor.sv
// tb_signal_monitor: table-driven check of window statistics plus reset-abort,
// back-to-back and saturation sequences.
module tb_signal_monitor;
    logic clk = 1'b0;
    logic reset;
    int   ncmp = 0;
    int   nfail = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    signal_monitor_if #(.CNT_W(8)) b1 ();
    signal_monitor_if #(.CNT_W(3)) b2 ();

    signal_monitor #(.WINDOW(8),  .CNT_W(8)) dut  (.clk(clk), .reset(reset), .mon(b1));
    signal_monitor #(.WINDOW(10), .CNT_W(3)) dut2 (.clk(clk), .reset(reset), .mon(b2));

    typedef struct {
        logic       r;
        logic [7:0] s;
        bit         mid;
        logic [7:0] er, ef, eh, em;
        logic       efl;
    } vec_t;

    vec_t v[5];
    int   last_done;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        ncmp++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s: got %0d want %0d", n, a, e);
        end
    endtask

    // Samples are applied MSB first; done must appear exactly 8 edges after start.
    task automatic run_win(input vec_t t, input string n);
        b1.start = 1'b1;
        b1.sig   = t.r;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            b1.sig   = t.s[7-i];
            b1.start = (t.mid && i == 3);
            if (i == 0) chk({n, " busy_first"}, 32'(b1.busy), 1);
            @(posedge clk); #1;
            if (i == 6) chk({n, " early_done"}, 32'(b1.done), 0);
        end
        b1.start = 1'b0;
        chk({n, " done"},  32'(b1.done), 1);
        chk({n, " busy"},  32'(b1.busy), 0);
        chk({n, " rise"},  32'(b1.rise_cnt), 32'(t.er));
        chk({n, " fall"},  32'(b1.fall_cnt), 32'(t.ef));
        chk({n, " high"},  32'(b1.high_cnt), 32'(t.eh));
        chk({n, " max"},   32'(b1.max_run), 32'(t.em));
        chk({n, " final"}, 32'(b1.final_level), 32'(t.efl));
    endtask

    initial begin
        v[0] = '{1'b0, 8'b00000000, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0};
        v[1] = '{1'b0, 8'b10101010, 1'b0, 8'd4, 8'd4, 8'd4, 8'd1, 1'b0};
        v[2] = '{1'b0, 8'b01110110, 1'b0, 8'd2, 8'd2, 8'd5, 8'd3, 1'b0};
        v[3] = '{1'b1, 8'b11111111, 1'b1, 8'd0, 8'd0, 8'd8, 8'd8, 1'b1};
        v[4] = '{1'b1, 8'b00000001, 1'b0, 8'd1, 8'd1, 8'd1, 8'd1, 1'b1};

        reset = 1'b1;
        b1.start = 1'b0; b1.sig = 1'b0;
        b2.start = 1'b0; b2.sig = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy",  32'(b1.busy), 0);
        chk("rst done",  32'(b1.done), 0);
        chk("rst rise",  32'(b1.rise_cnt), 0);
        chk("rst high",  32'(b1.high_cnt), 0);
        chk("rst final", 32'(b1.final_level), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Rows run back-to-back: each new start lands in the previous DONE cycle.
        last_done = 0;
        for (int i = 0; i < 5; i++) begin
            run_win(v[i], $sformatf("row%0d", i));
            if (i > 0) chk($sformatf("row%0d gap", i), 32'(cyc - last_done), 9);
            last_done = cyc;
        end

        // Abort: four samples of 1, then reset one cycle later.
        b1.start = 1'b1; b1.sig = 1'b0;
        @(posedge clk); #1;
        b1.start = 1'b0; b1.sig = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("abort busy_before", 32'(b1.busy), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort busy",  32'(b1.busy), 0);
        chk("abort done",  32'(b1.done), 0);
        chk("abort rise",  32'(b1.rise_cnt), 0);
        chk("abort fall",  32'(b1.fall_cnt), 0);
        chk("abort high",  32'(b1.high_cnt), 0);
        chk("abort max",   32'(b1.max_run), 0);
        chk("abort final", 32'(b1.final_level), 0);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk); #1;
                seen |= b1.done;
            end
            chk("abort no_done", 32'(seen), 0);
        end
        run_win(v[2], "fresh");

        // Saturation on the narrow instance.
        b2.start = 1'b1; b2.sig = 1'b1;
        @(posedge clk); #1;
        b2.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("sat early_done", 32'(b2.done), 0);
        @(posedge clk); #1;
        chk("sat done",  32'(b2.done), 1);
        chk("sat high",  32'(b2.high_cnt), 7);
        chk("sat max",   32'(b2.max_run), 7);
        chk("sat rise",  32'(b2.rise_cnt), 0);
        chk("sat fall",  32'(b2.fall_cnt), 0);
        chk("sat final", 32'(b2.final_level), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
